// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
//
// Round-robin arbiter plus output register stage for one router output port.
// Chooses one of four input channels (a..d), steers the external 4:1 data mux
// through mux_sel, and captures the selected beat into a valid/ready output
// register. A multi-beat packet locks the port to its source until the beat
// flagged "last" has transferred.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   [3:0] per-channel valid (0=a, 1=b, 2=c, 3=d)
//   in_last    in   [3:0] per-channel last-beat flag, qualified by in_valid
//   in_ready   out  [3:0] per-channel ready, one-hot or zero
//   mux_sel    out  [1:0] select for the external data mux
//   mux_out    in   [DATA_WIDTH-1:0] beat returned by the external mux
//   out_valid  out  output beat valid
//   out_last   out  output beat is the last of its packet
//   out_data   out  [DATA_WIDTH-1:0] registered output beat
//   out_ready  in   downstream ready
// -----------------------------------------------------------------------------
module noc_port_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in_valid,
    input  logic [3:0]            in_last,
    output logic [3:0]            in_ready,
    output logic [1:0]            mux_sel,
    input  logic [DATA_WIDTH-1:0] mux_out,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                  state_q;
    logic [1:0]              last_grant_q;
    logic [1:0]              lock_idx_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    logic                    load_en;
    logic [1:0]              grant;
    logic                    grant_vld;
    logic [1:0]              cand;
    logic                    xfer;

    // Grant selection. In IDLE the search starts one past the previous grant,
    // so the channel that was just served ends up with the lowest priority.
    // With nothing valid the grant (and thus mux_sel) parks on last_grant.
    always_comb begin
        load_en   = !out_valid_q || out_ready;
        grant     = last_grant_q;
        grant_vld = 1'b0;
        cand      = last_grant_q;
        if (state_q == ST_LOCK) begin
            grant     = lock_idx_q;
            grant_vld = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand = last_grant_q + 2'(k);
                if (!grant_vld && in_valid[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end
        // While locked the owner sees ready even if it is currently idle, so
        // no other channel can slip into the middle of the open packet.
        in_ready = 4'b0000;
        if (grant_vld) begin
            in_ready[grant] = load_en;
        end
        xfer = in_valid[grant] && in_ready[grant];
    end

    assign mux_sel   = grant;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    // Packet FSM and output register. Nothing moves while the output holds an
    // unaccepted beat; otherwise the register reloads (or empties) each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd3;
            lock_idx_q   <= 2'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else if (load_en) begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_data_q   <= mux_out;
                out_last_q   <= in_last[grant];
                last_grant_q <= grant;
                case (state_q)
                    ST_IDLE: begin
                        if (!in_last[grant]) begin
                            state_q    <= ST_LOCK;
                            lock_idx_q <= grant;
                        end
                    end
                    ST_LOCK: begin
                        if (in_last[grant]) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
module tb_noc_port_arbiter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    in_valid;
    logic [3:0]    in_last;
    logic [3:0]    in_ready;
    logic [1:0]    mux_sel;
    logic [DW-1:0] mux_out;
    logic          out_valid;
    logic          out_last;
    logic [DW-1:0] out_data;
    logic          out_ready;

    noc_port_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Per-channel source FIFOs: bit 16 = last flag, bits 15:0 = data.
    logic [16:0] mem [4][16];
    logic [3:0]  head [4];
    logic [3:0]  tail [4];
    logic [3:0]  mask;

    // Source valids and the external 4:1 data mux.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = (head[i] != tail[i]) && !mask[i];
            in_last[i]  = mem[i][head[i]][16];
        end
        mux_out = mem[mux_sel][head[mux_sel]][15:0];
    end

    logic [16:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    logic [1:0]    s_sel;
    logic [3:0]    s_rdy;
    logic          s_ov;
    logic [DW-1:0] s_od;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int ch, input logic [15:0] data, input logic last);
        mem[ch][tail[ch]] = {last, data};
        tail[ch] = tail[ch] + 4'd1;
    endtask

    task automatic expect_beat(input logic [15:0] data, input logic last);
        exp_q.push_back({last, data});
    endtask

    // One clock: sample settled outputs at negedge, score accepted beats,
    // then retire source beats that handshook on the rising edge.
    task automatic cycle();
        logic [3:0]  hs;
        logic [16:0] e;
        @(negedge clk);
        s_sel = mux_sel;
        s_rdy = in_ready;
        s_ov  = out_valid;
        s_od  = out_data;
        hs    = in_valid & in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {15'd0, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e[15:0]);
                check("beat_last", out_last, e[16]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) head[i] = head[i] + 4'd1;
        end
    endtask

    function automatic bit pending();
        bit p = (exp_q.size() != 0);
        for (int i = 0; i < 4; i++) begin
            if (head[i] != tail[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input string tag, output int n);
        n = 0;
        while (pending() && n < 200) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, {31'd0, (n < 200)}, 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            head[i] = '0;
            tail[i] = '0;
            for (int j = 0; j < 16; j++) mem[i][j] = '0;
        end
        mask      = 4'b0000;
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mux_sel", mux_sel, 3);
        check("rst_in_ready", in_ready, 0);

        // All four valid, single-beat packets: a, b, c, d, a
        load(0, 16'hA000, 1'b1); load(0, 16'hA001, 1'b1);
        load(1, 16'hB000, 1'b1); load(2, 16'hC000, 1'b1); load(3, 16'hD000, 1'b1);
        expect_beat(16'hA000, 1'b1); expect_beat(16'hB000, 1'b1);
        expect_beat(16'hC000, 1'b1); expect_beat(16'hD000, 1'b1);
        expect_beat(16'hA001, 1'b1);
        cycle();
        check("rr_first_sel", s_sel, 0);
        check("rr_first_rdy", s_rdy, 4'b0001);
        check("rr_first_latency", s_ov, 0);
        drain("rr", n);
        check("rr_throughput_cycles", n + 1, 6);

        // b sends a 3-beat packet while c is valid throughout
        load(1, 16'hB100, 1'b0); load(1, 16'hB101, 1'b0); load(1, 16'hB102, 1'b1);
        load(2, 16'hC100, 1'b1); load(2, 16'hC101, 1'b1);
        expect_beat(16'hB100, 1'b0); expect_beat(16'hB101, 1'b0);
        expect_beat(16'hB102, 1'b1);
        expect_beat(16'hC100, 1'b1); expect_beat(16'hC101, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("lock_b_sel", s_sel, 1);
            check("lock_b_rdy", s_rdy, 4'b0010);
        end
        cycle();
        check("after_lock_sel", s_sel, 2);
        drain("lock_b", n);

        // Backpressure: d beats, out_ready low for 4 cycles
        load(3, 16'hD200, 1'b1); load(3, 16'hD201, 1'b1); load(3, 16'hD202, 1'b1);
        expect_beat(16'hD200, 1'b1); expect_beat(16'hD201, 1'b1);
        expect_beat(16'hD202, 1'b1);
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("bp_in_ready", s_rdy, 0);
            check("bp_out_valid", s_ov, 1);
            check("bp_out_data", s_od, 16'hD200);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_rdy", s_rdy, 4'b1000);
        drain("bp", n);

        // Locked on d with a gap of 2 cycles while a is valid
        load(3, 16'hD300, 1'b0);
        cycle();
        mask = 4'b1000;
        load(3, 16'hD301, 1'b0); load(3, 16'hD302, 1'b1);
        load(0, 16'hA300, 1'b1);
        expect_beat(16'hD300, 1'b0); expect_beat(16'hD301, 1'b0);
        expect_beat(16'hD302, 1'b1); expect_beat(16'hA300, 1'b1);
        cycle();
        check("gap1_sel", s_sel, 3);
        check("gap1_rdy", s_rdy, 4'b1000);
        check("gap1_out_valid", s_ov, 1);
        cycle();
        check("gap2_sel", s_sel, 3);
        check("gap2_rdy", s_rdy, 4'b1000);
        check("gap2_bubble", s_ov, 0);
        mask = 4'b0000;
        drain("gap", n);

        // Reset in the middle of a b packet
        load(1, 16'hB400, 1'b0); load(1, 16'hB401, 1'b0); load(1, 16'hB402, 1'b1);
        expect_beat(16'hB400, 1'b0);
        cycle();
        cycle();
        check("pre_rst_out_valid", out_valid, 1);
        head[1] = tail[1];
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_mux_sel", mux_sel, 3);
        cycle();
        reset = 1'b0;
        load(0, 16'hA500, 1'b1); load(1, 16'hB500, 1'b1);
        expect_beat(16'hA500, 1'b1); expect_beat(16'hB500, 1'b1);
        cycle();
        check("post_rst_sel", s_sel, 0);
        check("post_rst_rdy", s_rdy, 4'b0001);
        drain("post_rst", n);

        // Idle: output empties, mux_sel parks on the last grant
        cycle();
        check("idle_out_valid", s_ov, 0);
        check("idle_sel", s_sel, 1);
        check("idle_rdy", s_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
